left_shift_logical_seq: RTL and testbench



---
 rtl/left_shift_logical_seq_pkg.sv | 15 +
 rtl/left_shift_logical_seq_stage.sv | 32 +++
 rtl/two_to_one_mux.sv | 11 +
 rtl/left_shift_logical_seq.sv | 104 ++++++++++
 tb/tb_left_shift_logical_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/left_shift_logical_seq_pkg.sv
// Shared shifter constants and FSM state encoding for the shift units.
package left_shift_logical_seq_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = $clog2(WIDTH);
    localparam int unsigned STG_W  = $clog2(STAGES);

    // Encoding 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/left_shift_logical_seq_stage.sv
// One combinational barrel stage: shifts left by 2**INDEX when i_en is set.
module left_shift_stage
    import left_shift_logical_seq_pkg::*;
#(
    parameter int unsigned INDEX = 0
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned SHIFT = 32'(1) << INDEX;

    // Per-bit mux: keep the bit, or take the bit SHIFT places below (zero fill).
    for (genvar b = 0; b < int'(WIDTH); b++) begin : g_bit
        logic w_shifted_bit;

        if (b >= int'(SHIFT)) begin : g_src
            assign w_shifted_bit = i_data[b-int'(SHIFT)];
        end else begin : g_zero
            assign w_shifted_bit = 1'b0;
        end

        two_to_one_mux u_mux (
            .i_a   (i_data[b]),
            .i_b   (w_shifted_bit),
            .i_sel (i_en),
            .o_y   (o_data[b])
        );
    end

endmodule

// File: rtl/two_to_one_mux.sv
// Single-bit 2:1 mux cell: o_y = i_sel ? i_b : i_a.
module two_to_one_mux (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/left_shift_logical_seq.sv
// Multi-cycle 32-bit logical left shifter: one binary-weighted stage per clock.
module left_shift_logical_seq
    import left_shift_logical_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done
);

    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(STAGES - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [STAGES-1:0]  r_amt;
    logic               r_big;
    logic [STG_W-1:0]   r_stage;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_stage_data [STAGES];
    logic [WIDTH-1:0]   w_shifted;
    logic               w_big;

    // Any set bit above the used shift-amount field means shift >= WIDTH.
    assign w_big = |B[WIDTH-1:STAGES];

    // All stages evaluate every cycle on the current work value.
    for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
        left_shift_stage #(
            .INDEX (s)
        ) u_stage (
            .i_data (r_work),
            .i_en   (r_amt[s]),
            .o_data (w_stage_data[s])
        );
    end

    // Pick the output of the stage selected by the stage counter.
    always_comb begin
        w_shifted = r_work;
        for (int unsigned s = 0; s < STAGES; s++) begin
            if (r_stage == STG_W'(s)) begin
                w_shifted = w_stage_data[s];
            end
        end
    end

    // FSM, operand registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_amt    <= '0;
            r_big    <= 1'b0;
            r_stage  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_work  <= A;
                        r_amt   <= B[STAGES-1:0];
                        r_big   <= w_big;
                        r_stage <= '0;
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_work  <= w_shifted;
                    r_stage <= r_stage + STG_W'(1);
                    if (r_stage == LAST_STAGE) begin
                        r_stage  <= '0;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= r_big ? '0 : w_shifted;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign R    = r_result;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_left_shift_logical_seq.sv
// Self-checking bench for left_shift_logical_seq against a transaction-level model.
module tb_left_shift_logical_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] R;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_mis = 0;

    left_shift_logical_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .R     (R),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_age counts cycles since acceptance (0 = no operation in flight).
    // An operation's result is A<<B, or 0 when the full 32-bit B is 32 or more;
    // it appears on R together with done six edges after acceptance.
    int          m_age;
    logic [31:0] m_pend;
    logic [31:0] m_R;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age  <= 0;
            m_pend <= '0;
            m_R    <= '0;
        end else if ((m_age == 0 || m_age == 6) && start) begin
            m_age  <= 1;
            m_pend <= (B >= 32) ? 32'h0 : (A << B);
        end else if (m_age >= 1 && m_age <= 5) begin
            m_age <= m_age + 1;
            if (m_age == 5) m_R <= m_pend;
        end else begin
            m_age <= 0;
        end
    end

    // Compare every cycle away from the rising edge while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_R", R, m_R);
            check("cyc_busy", 32'(busy), 32'(m_age >= 1 && m_age <= 5));
            check("cyc_done", 32'(done), 32'(m_age == 6));
        end
    end

    // One operation: check latency, busy length, result, and pin the model.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input string name);
        int lat = 0;
        int nb  = 0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) begin A = $urandom; B = $urandom; end
            if (busy) nb++;
            if (done) begin lat = i; break; end
        end
        check({name, "_latency"}, 32'(lat), 32'd6);
        check({name, "_busy_cycles"}, 32'(nb), 32'd5);
        check({name, "_R"}, R, exp_r);
        check({name, "_model"}, m_R, exp_r);
    endtask

    logic [31:0] a_tab [5] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b_tab [5] = '{32'd4,        32'd31,       32'd0,        32'd32,       32'h80000001};
    logic [31:0] r_tab [5] = '{32'h00000010, 32'h80000000, 32'h12345678, 32'h00000000, 32'h00000000};

    initial begin
        int nd, d1, d2, late_done, gap;
        logic [31:0] ra, rb, re;

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        #12;
        check("reset_R", R, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table.
        for (int t = 0; t < 5; t++) begin
            run_op(a_tab[t], b_tab[t], r_tab[t], $sformatf("dir%0d", t));
        end

        // start during SHIFT ignored, then start in DONE accepted back-to-back.
        @(negedge clk);
        A = 32'h1; B = 32'd4; start = 1'b1;
        nd = 0; d1 = 0; d2 = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 3) begin A = 32'hF; B = 32'd1; start = 1'b1; end
            if (done) begin
                nd++;
                if (nd == 1) d1 = i; else d2 = i;
                if (i == 6) begin
                    check("ign_R_first", R, 32'h00000010);
                    A = 32'hF; B = 32'd1; start = 1'b1;
                end
            end
        end
        check("ign_done_count", 32'(nd), 32'd2);
        check("ign_first_done", 32'(d1), 32'd6);
        check("b2b_second_done", 32'(d2), 32'd12);
        check("b2b_R", R, 32'h0000001E);

        // Asynchronous reset mid-SHIFT.
        @(negedge clk);
        A = 32'hFFFFFFFF; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_R", R, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        check("arst_no_done", 32'(late_done), 32'h0);
        run_op(32'hA5A5A5A5, 32'd8, 32'hA5A5A500, "post_rst");

        // Random pairs with B in 0..40, idle gaps so R must hold between ops.
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = 32'($urandom_range(0, 40));
            re = (rb >= 32) ? 32'h0 : (ra << rb);
            run_op(ra, rb, re, "rnd");
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
